// File: rtl/clint_timer_pkg.sv
// Shared constants for the memory-mapped machine timer: register offsets,
// the word access encoding and the CTRL bit position.
package timer_pkg;

   localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
   localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
   localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] OFF_CTRL        = 5'h10;

   // Same funct3 size encoding the data memory uses for a 32-bit access
   localparam logic [2:0] MEM_W = 3'b010;

   localparam int CTRL_EN_BIT = 0;

endpackage

// File: rtl/clint_timer_if.sv
// Data-memory side bus shared between the data memory and the timer window.
interface clint_timer_if;

   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rd_en;
   logic        wr_en;
   logic [2:0]  mem_type;
   logic [31:0] rdata;
   logic        hit;

   modport master (
      output addr, wdata, rd_en, wr_en, mem_type,
      input  rdata, hit
   );

   modport slave (
      input  addr, wdata, rd_en, wr_en, mem_type,
      output rdata, hit
   );

endinterface

// File: rtl/clint_timer_prescaler.sv
// Divides the clock into a one-cycle tick every PRESCALE enabled cycles;
// the count freezes while disabled so a paused timer resumes mid-period.
module timer_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] count;

   assign tick = en && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 16'd0;
      end else if (en) begin
         count <= tick ? 16'd0 : count + 16'd1;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// Machine timer window (mtime/mtimecmp/CTRL) on the data-memory bus; raises a
// registered level interrupt whenever mtime has reached mtimecmp.
module clint_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
   parameter int          PRESCALE   = 1,
   parameter logic        ENABLE_RST = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   clint_timer_if.slave   bus,
   output logic           timer_interupt
);

   logic [63:0] mtime;
   logic [63:0] mtime_next;
   logic [63:0] mtimecmp;
   logic [63:0] mtimecmp_next;
   logic        enable;
   logic        enable_next;
   logic        tick;
   logic        valid;
   logic        wr_valid;
   logic [4:0]  offset;

   assign offset   = bus.addr[4:0];
   assign bus.hit  = (bus.addr[31:5] == BASE_ADDR[31:5]);
   assign valid    = bus.hit && (bus.mem_type == MEM_W) && (bus.addr[1:0] == 2'b00);
   assign wr_valid = bus.wr_en && valid;

   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (enable),
      .tick (tick)
   );

   // A write to either mtime half replaces that cycle's increment entirely
   always_comb begin
      mtime_next    = mtime + {63'd0, tick};
      mtimecmp_next = mtimecmp;
      enable_next   = enable;
      if (wr_valid) begin
         case (offset)
            OFF_MTIME_LO:    mtime_next         = {mtime[63:32], bus.wdata};
            OFF_MTIME_HI:    mtime_next         = {bus.wdata, mtime[31:0]};
            OFF_MTIMECMP_LO: mtimecmp_next      = {mtimecmp[63:32], bus.wdata};
            OFF_MTIMECMP_HI: mtimecmp_next      = {bus.wdata, mtimecmp[31:0]};
            OFF_CTRL:        enable_next        = bus.wdata[CTRL_EN_BIT];
            default:         mtime_next         = mtime + {63'd0, tick};
         endcase
      end
   end

   always_comb begin
      bus.rdata = 32'h0;
      if (bus.rd_en && valid) begin
         case (offset)
            OFF_MTIME_LO:    bus.rdata = mtime[31:0];
            OFF_MTIME_HI:    bus.rdata = mtime[63:32];
            OFF_MTIMECMP_LO: bus.rdata = mtimecmp[31:0];
            OFF_MTIMECMP_HI: bus.rdata = mtimecmp[63:32];
            OFF_CTRL:        bus.rdata = {31'd0, enable};
            default:         bus.rdata = 32'h0;
         endcase
      end
   end

   // Compare on post-edge values so a deadline write updates the IRQ that edge
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime          <= 64'h0;
         mtimecmp       <= 64'hFFFF_FFFF_FFFF_FFFF;
         enable         <= ENABLE_RST;
         timer_interupt <= 1'b0;
      end else begin
         mtime          <= mtime_next;
         mtimecmp       <= mtimecmp_next;
         enable         <= enable_next;
         timer_interupt <= (mtime_next >= mtimecmp_next);
      end
   end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: a PRESCALE=1 and a PRESCALE=4 instance
// share one bus driver, selected by sel; reads are checked through a scoreboard.
module tb_clint_timer;
   import timer_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  mem_type;
      logic [31:0] exp_rdata;
      logic        exp_hit;
      string       name;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst1;
   logic        rst4;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rd_en;
   logic        wr_en;
   logic [2:0]  mem_type;
   logic        sel;
   logic        irq1;
   logic        irq4;
   logic [31:0] rdata_sel;
   logic        hit_sel;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vec[11];
   sb_t  sb_q[$];

   clint_timer_if bus1 ();
   clint_timer_if bus4 ();

   assign bus1.addr     = addr;
   assign bus1.wdata    = wdata;
   assign bus1.mem_type = mem_type;
   assign bus1.rd_en    = rd_en && !sel;
   assign bus1.wr_en    = wr_en && !sel;
   assign bus4.addr     = addr;
   assign bus4.wdata    = wdata;
   assign bus4.mem_type = mem_type;
   assign bus4.rd_en    = rd_en && sel;
   assign bus4.wr_en    = wr_en && sel;
   assign rdata_sel     = sel ? bus4.rdata : bus1.rdata;
   assign hit_sel       = sel ? bus4.hit : bus1.hit;

   clint_timer #(.PRESCALE(1)) dut1 (
      .clk            (clk),
      .rst            (rst1),
      .bus            (bus1.slave),
      .timer_interupt (irq1)
   );

   clint_timer #(.PRESCALE(4)) dut4 (
      .clk            (clk),
      .rst            (rst4),
      .bus            (bus4.slave),
      .timer_interupt (irq4)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] a, input logic [2:0] mt,
                               input logic [31:0] d, input logic h, input string n);
      vec_t v;
      v.addr = a; v.mem_type = mt; v.exp_rdata = d; v.exp_hit = h; v.name = n;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One store cycle: driven after a falling edge, captured on the next rising edge
   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] mt);
      @(negedge clk);
      addr = a; wdata = d; mem_type = mt; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic read_expect(input logic [31:0] a, input logic [2:0] mt,
                              input logic [31:0] exp, input string name);
      sb_t e;
      addr = a; mem_type = mt; rd_en = 1'b1;
      e.name = name; e.exp = exp;
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      check_output(e.name, rdata_sel, e.exp);
      rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst1 = 1'b1; rst4 = 1'b1; sel = 1'b0;
      addr = 32'h0; wdata = 32'h0; rd_en = 1'b0; wr_en = 1'b0; mem_type = MEM_W;

      vec[0]  = mk(32'h400, MEM_W,  32'h0,         1'b1, "reset_mtime_lo");
      vec[1]  = mk(32'h404, MEM_W,  32'h0,         1'b1, "reset_mtime_hi");
      vec[2]  = mk(32'h408, MEM_W,  32'hFFFF_FFFF, 1'b1, "reset_cmp_lo");
      vec[3]  = mk(32'h40C, MEM_W,  32'hFFFF_FFFF, 1'b1, "reset_cmp_hi");
      vec[4]  = mk(32'h410, MEM_W,  32'h1,         1'b1, "reset_ctrl");
      vec[5]  = mk(32'h420, MEM_W,  32'h0,         1'b0, "miss_0x420");
      vec[6]  = mk(32'h408, 3'b001, 32'h0,         1'b1, "half_read_cmp");
      vec[7]  = mk(32'h408, 3'b000, 32'h0,         1'b1, "byte_read_cmp");
      vec[8]  = mk(32'h409, MEM_W,  32'h0,         1'b1, "misaligned_read");
      vec[9]  = mk(32'h418, MEM_W,  32'h0,         1'b1, "reserved_0x18");
      vec[10] = mk(32'h408, MEM_W,  32'd777,       1'b1, "cmp_lo_kept");

      // Reset values are read while reset is still held, so nothing can count
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         read_expect(vec[i].addr, vec[i].mem_type, vec[i].exp_rdata, vec[i].name);
         check_output({vec[i].name, "_hit"}, {31'd0, hit_sel}, {31'd0, vec[i].exp_hit});
      end
      check_output("reset_irq1", {31'd0, irq1}, 32'd0);
      check_output("reset_irq4", {31'd0, irq4}, 32'd0);
      @(negedge clk);
      rst1 = 1'b0; rst4 = 1'b0;

      // Deadline at 25: interrupt rises on the edge mtime reaches it
      apply_stimulus(32'h404, 32'h0, MEM_W);
      apply_stimulus(32'h40C, 32'h0, MEM_W);
      apply_stimulus(32'h408, 32'd25, MEM_W);
      apply_stimulus(32'h400, 32'd10, MEM_W);
      read_expect(32'h400, MEM_W, 32'd10, "t3_mtime_set");
      check_output("t3_irq_low", {31'd0, irq1}, 32'd0);
      repeat (14) @(negedge clk);
      check_output("t3_irq_before", {31'd0, irq1}, 32'd0);
      @(negedge clk);
      check_output("t3_irq_rise", {31'd0, irq1}, 32'd1);
      read_expect(32'h400, MEM_W, 32'd25, "t3_mtime_at_rise");
      repeat (3) @(negedge clk);
      check_output("t3_irq_level", {31'd0, irq1}, 32'd1);
      apply_stimulus(32'h408, 32'd1000, MEM_W);
      check_output("t3_irq_drop", {31'd0, irq1}, 32'd0);

      // Simultaneous load and store: old value returned, new value stored
      @(negedge clk);
      wdata = 32'd777; wr_en = 1'b1;
      read_expect(32'h408, MEM_W, 32'd1000, "rw_old_value");
      @(negedge clk);
      wr_en = 1'b0;
      read_expect(32'h408, MEM_W, 32'd777, "rw_new_value");

      // Store in a tick cycle wins over the increment
      apply_stimulus(32'h400, 32'd5, MEM_W);
      read_expect(32'h400, MEM_W, 32'd5, "t5_write_wins");
      @(negedge clk);
      read_expect(32'h400, MEM_W, 32'd6, "t5_next_tick");

      // Carry from LO into HI, then full 64-bit wrap
      apply_stimulus(32'h404, 32'h0, MEM_W);
      apply_stimulus(32'h400, 32'hFFFF_FFFE, MEM_W);
      read_expect(32'h400, MEM_W, 32'hFFFF_FFFE, "t4_lo_set");
      repeat (2) @(negedge clk);
      read_expect(32'h400, MEM_W, 32'h0, "t4_carry_lo");
      read_expect(32'h404, MEM_W, 32'h1, "t4_carry_hi");
      apply_stimulus(32'h404, 32'hFFFF_FFFF, MEM_W);
      apply_stimulus(32'h400, 32'hFFFF_FFFF, MEM_W);
      read_expect(32'h400, MEM_W, 32'hFFFF_FFFF, "t4_max_lo");
      read_expect(32'h404, MEM_W, 32'hFFFF_FFFF, "t4_max_hi");
      check_output("t4_irq_at_max", {31'd0, irq1}, 32'd1);
      @(negedge clk);
      read_expect(32'h400, MEM_W, 32'h0, "t4_wrap_lo");
      read_expect(32'h404, MEM_W, 32'h0, "t4_wrap_hi");
      check_output("t4_irq_after_wrap", {31'd0, irq1}, 32'd0);

      // Non-word and misaligned stores must leave MTIMECMP alone
      apply_stimulus(32'h408, 32'd5, 3'b001);
      apply_stimulus(32'h409, 32'd5, MEM_W);
      apply_stimulus(32'h40A, 32'd6, 3'b000);
      for (int i = 6; i < 11; i++) begin
         read_expect(vec[i].addr, vec[i].mem_type, vec[i].exp_rdata, vec[i].name);
         check_output({vec[i].name, "_hit"}, {31'd0, hit_sel}, {31'd0, vec[i].exp_hit});
      end

      // PRESCALE=4 instance: one increment per four enabled cycles, frozen when disabled
      sel = 1'b1;
      @(negedge clk);
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      repeat (39) @(negedge clk);
      read_expect(32'h400, MEM_W, 32'd9, "t2_after_39");
      @(negedge clk);
      read_expect(32'h400, MEM_W, 32'd10, "t2_after_40");
      apply_stimulus(32'h410, 32'h0, MEM_W);
      read_expect(32'h410, MEM_W, 32'h0, "t2_ctrl_off");
      repeat (20) @(negedge clk);
      read_expect(32'h400, MEM_W, 32'd10, "t2_hold");
      sel = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
Memory-mapped machine timer (mtime/mtimecmp) that generates the machine timer interrupt consumed by the CSR/trap logic as `timer_interupt`.
- Sits on the data-memory bus beside the data memory and shares `addr`/`wdata`/`rd_en`/`wr_en`/`mem_type` with it.
- Asserts `hit` when it owns the address; the top level then steers writeback data from this block instead of data memory.
- Replaces the free-running fixed-period timer, so software can program interrupt deadlines.

Parameters:
BASE_ADDR, 32'h0000_0400, byte base of the 32-byte register window; must be 32-byte aligned.
PRESCALE, 1, clock cycles per mtime increment; legal range 1..65535.
ENABLE_RST, 1'b1, reset value of the CTRL.enable bit.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
addr  input  32  byte address from the ALU result
wdata  input  32  store data (rs2 value)
rd_en  input  1  load strobe
wr_en  input  1  store strobe
mem_type  input  3  access size, funct3 encoding
rdata  output  32  load data, combinational
hit  output  1  addr[31:5] == BASE_ADDR[31:5], combinational
timer_interupt  output  1  registered level interrupt request

Behaviour:
- Register map (offset = addr[4:0]):
  - 0x00 MTIME_LO, 0x04 MTIME_HI.
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI.
  - 0x10 CTRL: bit0 = enable; other bits read 0, writes to them ignored.
  - 0x14–0x1C: reserved, read 0, writes ignored.
- Reset (rst=1 at a clock edge):
  - mtime = 64'h0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; enable = ENABLE_RST.
  - Prescaler count = 0; `timer_interupt` = 0.
  - Reset mid-count or mid-interrupt clears everything on that edge.
- Valid access: hit && mem_type == MEM_W && addr[1:0] == 2'b00. Any other access is treated as follows:
  - Write: ignored, no state change.
  - Read: `rdata` = 0.
- Read:
  - `rdata` = selected register's current (pre-edge) value when rd_en && valid access; otherwise 32'h0.
  - Zero latency, because the single-cycle datapath writes back loads in the same cycle.
- Write:
  - Takes effect at the clock edge when wr_en && valid access.
  - If rd_en and wr_en are both high: the write happens, and `rdata` shows the old value.
- Prescaler:
  - When enable=1, the count runs 0..PRESCALE-1 and produces a one-cycle `tick` when count == PRESCALE-1, then wraps to 0.
  - When enable=0, the count holds and no tick is produced.
  - PRESCALE=1 gives a tick every enabled cycle.
- mtime:
  - On a tick, increments as a full 64-bit value; the carry from LO propagates into HI in the same cycle.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
- Write/tick collision: a write to MTIME_LO or MTIME_HI in a tick cycle wins.
  - The written half takes wdata, the other half keeps its value, and there is no increment that cycle.
  - The prescaler count still advances.
- Interrupt:
  - Each edge: `timer_interupt` <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare of the post-edge values.
  - Level output; stays high until mtimecmp is raised above mtime, or mtime is written/wraps below mtimecmp.
  - The compare is independent of enable.
  - Writing MTIMECMP_LO/HI updates the compare in the same edge, so `timer_interupt` follows on that edge.
- Registering: all state in flops. Only `rdata` and `hit` are combinational.

Decomposition:
- Package `timer_pkg`:
  - Offset constants OFF_MTIME_LO/HI, OFF_MTIMECMP_LO/HI, OFF_CTRL (5-bit).
  - MEM_W = 3'b010 (shared with the data-memory size encoding).
  - CTRL_EN_BIT = 0.
- Sub-module `timer_prescaler` (clk, rst, en → tick), parameterised by PRESCALE.
- Decode, registers and compare stay in `clint_timer`.

Test Plan:
1. Reset → every register read returns its reset value:
   - MTIME_LO/HI = 0; MTIMECMP_LO/HI = 32'hFFFF_FFFF; CTRL = 1.
   - `timer_interupt` = 0; `hit` = 1 at addr 0x400, 0 at 0x420.
2. PRESCALE=4, enable held → after 40 cycles MTIME_LO = 10; write CTRL=0, wait 20 cycles → value unchanged.
3. Write MTIMECMP_HI=0, then MTIMECMP_LO=25 (PRESCALE=1, from reset):
   - `timer_interupt` rises on the edge where mtime becomes 25.
   - Writing MTIMECMP_LO=1000 drops it on that edge.
4. Write MTIME_LO=32'hFFFF_FFFE, HI=0 → two ticks later LO=0 and HI=1; MTIME_HI=LO=32'hFFFF_FFFF → wraps to 64'h0 next tick.
5. Write MTIME_LO=5 in a tick cycle → reads 5 the next cycle, not 6; the next tick yields 6.
6. Invalid accesses to offset 0x08 with a non-word `mem_type` or a misaligned address (e.g. 0x409):
   - Writes have no effect on MTIMECMP.
   - Reads return 0.
   - Read of reserved offset 0x18 returns 0.
